sys_tx_control: RTL and testbench

- Transmit-side sequencer of the low-power communication system.
- Accepts two result sources: register-file read data (1 byte) and ALU result (2 bytes).
- Holds one pending request per source, arbitrates round-robin, and serialises bytes into the TX FIFO write port, honouring FIFO_Full.
- Sits between reg file/ALU outputs and the async FIFO feeding the UART transmitter.

---
 rtl/sys_tx_control.sv | 119 +++++++++++
 tb/tb_sys_tx_control.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_tx_control.sv
// Transmit sequencer: holds one reg-file byte and one ALU word,
// arbitrates round-robin and serialises bytes into the TX FIFO.
module sys_tx_control #(
    parameter int width = 8
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [width-1:0]   RdData,
    input  logic               RdData_Valid,
    input  logic [2*width-1:0] ALU_OUT,
    input  logic               ALU_Valid,
    input  logic               FIFO_Full,
    output logic [width-1:0]   FIFO_WrData,
    output logic               FIFO_WrEN,
    output logic               Busy,
    output logic               Drop_Err
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_RD,
        SEND_ALU_LO,
        SEND_ALU_HI
    } state_t;

    state_t             state;
    logic               rd_pend;
    logic               alu_pend;
    logic [width-1:0]   rd_hold;
    logic [2*width-1:0] alu_hold;
    logic               last_alu;

    logic rd_rel;
    logic alu_rel;
    logic rd_acc;
    logic alu_acc;
    logic rd_drop;
    logic alu_drop;

    assign FIFO_WrEN = (state != IDLE) && !FIFO_Full;
    assign Busy      = (state != IDLE) || rd_pend || alu_pend;

    // A slot frees on the edge its last byte is written, so a strobe
    // landing on that same edge may refill it.
    assign rd_rel   = (state == SEND_RD) && FIFO_WrEN;
    assign alu_rel  = (state == SEND_ALU_HI) && FIFO_WrEN;
    assign rd_acc   = !rd_pend || rd_rel;
    assign alu_acc  = !alu_pend || alu_rel;
    assign rd_drop  = RdData_Valid && !rd_acc;
    assign alu_drop = ALU_Valid && !alu_acc;

    always_comb begin
        FIFO_WrData = '0;
        unique case (state)
            SEND_RD:     FIFO_WrData = rd_hold;
            SEND_ALU_LO: FIFO_WrData = alu_hold[width-1:0];
            SEND_ALU_HI: FIFO_WrData = alu_hold[2*width-1:width];
            default:     FIFO_WrData = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            rd_pend  <= 1'b0;
            alu_pend <= 1'b0;
            rd_hold  <= '0;
            alu_hold <= '0;
            last_alu <= 1'b1;
            Drop_Err <= 1'b0;
        end else begin
            Drop_Err <= rd_drop || alu_drop;

            if (RdData_Valid && rd_acc) begin
                rd_hold <= RdData;
                rd_pend <= 1'b1;
            end else if (rd_rel) begin
                rd_pend <= 1'b0;
            end

            if (ALU_Valid && alu_acc) begin
                alu_hold <= ALU_OUT;
                alu_pend <= 1'b1;
            end else if (alu_rel) begin
                alu_pend <= 1'b0;
            end

            // last_served only moves when both sources contend
            unique case (state)
                IDLE: begin
                    if (rd_pend && alu_pend) begin
                        if (last_alu) begin
                            state    <= SEND_RD;
                            last_alu <= 1'b0;
                        end else begin
                            state    <= SEND_ALU_LO;
                            last_alu <= 1'b1;
                        end
                    end else if (rd_pend) begin
                        state <= SEND_RD;
                    end else if (alu_pend) begin
                        state <= SEND_ALU_LO;
                    end
                end
                SEND_RD: begin
                    if (FIFO_WrEN) state <= IDLE;
                end
                SEND_ALU_LO: begin
                    if (FIFO_WrEN) state <= SEND_ALU_HI;
                end
                SEND_ALU_HI: begin
                    if (FIFO_WrEN) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_tx_control.sv
// Bench for sys_tx_control: scoreboard of expected FIFO bytes
// plus cycle-accurate scenario checks.
module tb_sys_tx_control;

    localparam int W = 8;

    logic           CLK;
    logic           Reset;
    logic [W-1:0]   RdData;
    logic           RdData_Valid;
    logic [2*W-1:0] ALU_OUT;
    logic           ALU_Valid;
    logic           FIFO_Full;
    logic [W-1:0]   FIFO_WrData;
    logic           FIFO_WrEN;
    logic           Busy;
    logic           Drop_Err;

    int vectors;
    int miscompares;
    logic [W-1:0] exp_q[$];

    sys_tx_control #(.width(W)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .RdData(RdData),
        .RdData_Valid(RdData_Valid),
        .ALU_OUT(ALU_OUT),
        .ALU_Valid(ALU_Valid),
        .FIFO_Full(FIFO_Full),
        .FIFO_WrData(FIFO_WrData),
        .FIFO_WrEN(FIFO_WrEN),
        .Busy(Busy),
        .Drop_Err(Drop_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard: every write the DUT issues must match the next expected byte
    always @(negedge CLK) begin
        if (Reset && FIFO_WrEN) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_extra: got write %h, required no write",
                         FIFO_WrData);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (FIFO_WrData !== e) begin
                    miscompares++;
                    $display("FAIL sb_data: got %h, required %h",
                             FIFO_WrData, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || Busy) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d left busy=%b, required 0 left busy=0",
                     name, exp_q.size(), Busy);
        end
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        RdData = '0;
        RdData_Valid = 1'b0;
        ALU_OUT = '0;
        ALU_Valid = 1'b0;
        FIFO_Full = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({FIFO_WrEN, Busy, Drop_Err} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_flags: got %b, required 000",
                     {FIFO_WrEN, Busy, Drop_Err});
        end
        vectors++;
        if (FIFO_WrData !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_data: got %h, required 00", FIFO_WrData);
        end
    endtask

    task automatic test_single_rd();
        tick();
        RdData = 8'h5A;
        RdData_Valid = 1'b1;
        exp_q.push_back(8'h5A);
        @(negedge CLK);
        vectors++;
        if ({Busy, FIFO_WrEN} !== 2'b00) begin
            miscompares++;
            $display("FAIL rd_c0: got %b, required 00", {Busy, FIFO_WrEN});
        end
        tick();
        RdData_Valid = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({Busy, FIFO_WrEN} !== 2'b10) begin
            miscompares++;
            $display("FAIL rd_c1: got %b, required 10", {Busy, FIFO_WrEN});
        end
        tick();
        @(negedge CLK);
        vectors++;
        if ({Busy, FIFO_WrEN, FIFO_WrData} !== {2'b11, 8'h5A}) begin
            miscompares++;
            $display("FAIL rd_c2: got %b %h, required 11 5a",
                     {Busy, FIFO_WrEN}, FIFO_WrData);
        end
        tick();
        @(negedge CLK);
        vectors++;
        if ({Busy, FIFO_WrEN} !== 2'b00) begin
            miscompares++;
            $display("FAIL rd_c3: got %b, required 00", {Busy, FIFO_WrEN});
        end
        drain("rd");
    endtask

    task automatic test_alu_frame();
        ALU_OUT = 16'hBEEF;
        ALU_Valid = 1'b1;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'h11);
        tick();
        ALU_Valid = 1'b0;
        tick();
        RdData = 8'h11;
        RdData_Valid = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({FIFO_WrEN, FIFO_WrData} !== {1'b1, 8'hEF}) begin
            miscompares++;
            $display("FAIL alu_lo: got %b %h, required 1 ef",
                     FIFO_WrEN, FIFO_WrData);
        end
        tick();
        RdData_Valid = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({FIFO_WrEN, FIFO_WrData} !== {1'b1, 8'hBE}) begin
            miscompares++;
            $display("FAIL alu_hi: got %b %h, required 1 be",
                     FIFO_WrEN, FIFO_WrData);
        end
        drain("alu");
    endtask

    task automatic test_both();
        RdData = 8'h22;
        ALU_OUT = 16'h1234;
        RdData_Valid = 1'b1;
        ALU_Valid = 1'b1;
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        tick();
        RdData_Valid = 1'b0;
        ALU_Valid = 1'b0;
        drain("both1");
        RdData = 8'h33;
        ALU_OUT = 16'h5678;
        RdData_Valid = 1'b1;
        ALU_Valid = 1'b1;
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h56);
        exp_q.push_back(8'h33);
        tick();
        RdData_Valid = 1'b0;
        ALU_Valid = 1'b0;
        drain("both2");
    endtask

    task automatic test_full_stall();
        ALU_OUT = 16'hA1B2;
        ALU_Valid = 1'b1;
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'hA1);
        tick();
        ALU_Valid = 1'b0;
        tick();
        @(negedge CLK);
        vectors++;
        if ({FIFO_WrEN, FIFO_WrData} !== {1'b1, 8'hB2}) begin
            miscompares++;
            $display("FAIL stall_lo: got %b %h, required 1 b2",
                     FIFO_WrEN, FIFO_WrData);
        end
        tick();
        FIFO_Full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            vectors++;
            if ({FIFO_WrEN, FIFO_WrData} !== {1'b0, 8'hA1}) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got %b %h, required 0 a1",
                         i, FIFO_WrEN, FIFO_WrData);
            end
            if (i < 4) tick();
        end
        tick();
        FIFO_Full = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({FIFO_WrEN, FIFO_WrData} !== {1'b1, 8'hA1}) begin
            miscompares++;
            $display("FAIL stall_rel: got %b %h, required 1 a1",
                     FIFO_WrEN, FIFO_WrData);
        end
        tick();
        @(negedge CLK);
        vectors++;
        if ({FIFO_WrEN, Busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL stall_after: got %b, required 00",
                     {FIFO_WrEN, Busy});
        end
        drain("stall");
    endtask

    task automatic test_drop();
        FIFO_Full = 1'b1;
        RdData = 8'h5C;
        RdData_Valid = 1'b1;
        exp_q.push_back(8'h5C);
        exp_q.push_back(8'h66);
        tick();
        RdData_Valid = 1'b0;
        tick();
        RdData = 8'h44;
        RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({Drop_Err, FIFO_WrEN, FIFO_WrData} !== {2'b10, 8'h5C}) begin
            miscompares++;
            $display("FAIL drop_pulse: got %b %h, required 10 5c",
                     {Drop_Err, FIFO_WrEN}, FIFO_WrData);
        end
        tick();
        @(negedge CLK);
        vectors++;
        if (Drop_Err !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_one: got %b, required 0", Drop_Err);
        end
        tick();
        FIFO_Full = 1'b0;
        RdData = 8'h66;
        RdData_Valid = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({FIFO_WrEN, FIFO_WrData} !== {1'b1, 8'h5C}) begin
            miscompares++;
            $display("FAIL drop_orig: got %b %h, required 1 5c",
                     FIFO_WrEN, FIFO_WrData);
        end
        tick();
        RdData_Valid = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({Drop_Err, Busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL drop_relacc: got %b, required 01",
                     {Drop_Err, Busy});
        end
        drain("drop");
    endtask

    task automatic test_reset_mid();
        ALU_OUT = 16'hCAFE;
        ALU_Valid = 1'b1;
        exp_q.push_back(8'hFE);
        tick();
        ALU_Valid = 1'b0;
        tick();
        @(negedge CLK);
        vectors++;
        if ({FIFO_WrEN, FIFO_WrData} !== {1'b1, 8'hFE}) begin
            miscompares++;
            $display("FAIL rmid_lo: got %b %h, required 1 fe",
                     FIFO_WrEN, FIFO_WrData);
        end
        tick();
        Reset = 1'b0;
        #1;
        vectors++;
        if ({FIFO_WrEN, Busy, Drop_Err, FIFO_WrData} !== 11'd0) begin
            miscompares++;
            $display("FAIL rmid_async: got %b %h, required 000 00",
                     {FIFO_WrEN, Busy, Drop_Err}, FIFO_WrData);
        end
        tick();
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            vectors++;
            if ({FIFO_WrEN, Busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL rmid_post%0d: got %b, required 00",
                         i, {FIFO_WrEN, Busy});
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rmid_q: got %0d pending, required 0",
                     exp_q.size());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single_rd();
        test_alu_frame();
        test_both();
        test_full_stall();
        test_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
